miriscv_dp_mem_model: RTL and testbench
=======================================

Name: miriscv_dp_mem_model

Overview:
- Parametrised dual-port memory responder for miriscv_core: one instruction (read-only) port and one data (read/write) port.
- Same req/rvalid protocol as the core expects, with no grant signal: every request is accepted in the cycle req is high.
- Adds over the previous bench memory: configurable per-port response latency, bounded word array with out-of-range detection, a side-band preload port, and a signature-write end-of-test detector with a programmable delay.
- Sits between the core and the bench in all practice testbenches.

Parameters:
- DEPTH_WORDS, 65536, number of 32-bit words in the array.
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0; must be 4-byte aligned.
- INSTR_LATENCY, 1, cycles from instr request to instr_rvalid_o; legal range 1..8.
- DATA_LATENCY, 1, cycles from data request to data_rvalid_o; legal range 1..8.
- DONE_DELAY, 10, cycles from signature-write detection to test_done_o.

Ports:
- clk  in  1  clock
- arstn  in  1  reset, asynchronous, active-low
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch byte address
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch data
- data_req_i  in  1  data request
- data_we_i  in  1  1 = write
- data_be_i  in  4  byte enables
- data_addr_i  in  32  data byte address
- data_wdata_i  in  32  write data
- data_rvalid_o  out  1  data response valid (reads and writes)
- data_rdata_o  out  32  read data
- load_we_i  in  1  preload word write
- load_addr_i  in  32  preload byte address
- load_wdata_i  in  32  preload word, all 4 bytes
- signature_addr_i  in  32  end-of-test signature address, quasi-static
- test_done_o  out  1  sticky end-of-test flag
- err_o  out  1  sticky out-of-range access flag

Behaviour:
- Reset values: all rvalid outputs, rdata outputs, test_done_o and err_o = 0; latency pipelines flushed; done counter cleared.
- Array contents are not affected by reset. Reset mid-operation drops in-flight responses and keeps memory contents.
- Address map: word index = (addr - BASE_ADDR) >> 2; addr[1:0] is ignored (aligned down). An address is out of range if addr < BASE_ADDR or index >= DEPTH_WORDS.
- Read sampling: the array is read in the request cycle t. The response appears on rvalid/rdata in cycle t+LATENCY for one cycle. Back-to-back requests give back-to-back responses, with no bubbles and no reordering.
- Data write: bytes with be=1 are written at the clock edge ending cycle t. Response has data_rvalid_o=1 at t+DATA_LATENCY with data_rdata_o=0.
- Hazards:
  - Same-cycle instr read and data write to the same word: the read returns old data.
  - A read in cycle t+1 returns new data.
  - A data read and a data write cannot coincide (single data port).
- Load port: full-word write, any cycle, including during reset. On a same-word collision with a data write in the same cycle, load data wins for all bytes. Out-of-range loads are dropped and set err_o.
- Out-of-range handling: reads return 32'h0000_0000 with normal latency and set err_o. Writes are dropped and set err_o. err_o stays set until reset.
- rdata outputs hold 0 whenever rvalid is 0.
- Done detector FSM:
  - IDLE: on data_req_i & data_we_i & data_addr_i==signature_addr_i & data_wdata_i==0 (be ignored) -> COUNT, counter = DONE_DELAY-1.
  - COUNT: decrement each cycle; at 0 -> DONE.
  - DONE: test_done_o=1, terminal.
  - DONE_DELAY=0: go straight from IDLE to DONE, test_done_o high the cycle after detection.
  - Further signature writes in COUNT or DONE are ignored.
- Elaboration error if any latency is outside 1..8, BASE_ADDR is unaligned, or DEPTH_WORDS < 1.

Decomposition:
- Package miriscv_mem_model_pkg holds WORD_W=32, BE_W=4, MAX_LATENCY=8, OOR_RDATA=32'h0, and the done-FSM state enum (IDLE, COUNT, DONE).
- Sub-module miriscv_mem_rsp_pipe, parameter LATENCY: a valid+data shift register with async reset. Instantiated once per port.

Test Plan:
- Preload word 0x0000_0013 at 0x0 via load port; instr req at 0x0 with INSTR_LATENCY=3 -> instr_rvalid_o high exactly 3 cycles later with rdata 0x0000_0013, low otherwise.
- Data write 0xAABBCCDD be=4'b0101 to 0x100 over word 0x11223344, then read 0x102 -> rdata 0x11BB33DD; write response rdata 0.
- Instr reads on 5 consecutive cycles at 0x0,0x4,...,0x10 -> 5 consecutive rvalid cycles, data in order.
- Same-cycle instr read and data write of 0xFFFF_FFFF to word 0x20 (old value 0x1) -> fetch returns 0x1; fetch next cycle returns 0xFFFF_FFFF.
- DEPTH_WORDS=16: read at 0x40 -> rdata 0, err_o rises and stays high; write at 0x40 leaves all words unchanged.
- signature_addr_i=0x8000_0000: write 0 there -> test_done_o high after 10 cycles; write 1 there -> no done; arstn pulse mid-COUNT -> test_done_o stays 0.

Source files
------------

// File: rtl/miriscv_mem_model_pkg.sv
// Shared constants, done-detector state encoding and byte-merge helper
// for the dual-port memory responder.
package miriscv_mem_model_pkg;

    localparam int          WORD_W      = 32;
    localparam int          BE_W        = 4;
    localparam int          MAX_LATENCY = 8;
    localparam logic [31:0] OOR_RDATA   = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } done_state_e;

    function automatic logic [WORD_W-1:0] be_merge(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [WORD_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/miriscv_mem_rsp_pipe.sv
// Fixed-latency response pipeline: valid+data shift register whose data
// stage is forced to zero when the entering beat is not valid.
module miriscv_mem_rsp_pipe
    import miriscv_mem_model_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              arstn,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data
);

    logic [LATENCY-1:0] valid_r;
    logic [WORD_W-1:0]  data_r [LATENCY];

    // Shift responses one stage per cycle; reset flushes in-flight beats.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            valid_r <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_r[i] <= '0;
            end
        end else begin
            valid_r[0] <= in_valid;
            data_r[0]  <= in_valid ? in_data : '0;
            for (int i = 1; i < LATENCY; i++) begin
                valid_r[i] <= valid_r[i-1];
                data_r[i]  <= data_r[i-1];
            end
        end
    end

    assign out_valid = valid_r[LATENCY-1];
    assign out_data  = data_r[LATENCY-1];

endmodule

// File: rtl/miriscv_dp_mem_model.sv
// Dual-port memory responder for miriscv_core: read-only fetch port, read/write
// data port, side-band preload, out-of-range flag and end-of-test detector.
module miriscv_dp_mem_model
    import miriscv_mem_model_pkg::*;
#(
    parameter int          DEPTH_WORDS   = 65536,
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int          INSTR_LATENCY = 1,
    parameter int          DATA_LATENCY  = 1,
    parameter int          DONE_DELAY    = 10
) (
    input  logic              clk,
    input  logic              arstn,
    input  logic              instr_req_i,
    input  logic [31:0]       instr_addr_i,
    output logic              instr_rvalid_o,
    output logic [WORD_W-1:0] instr_rdata_o,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [BE_W-1:0]   data_be_i,
    input  logic [31:0]       data_addr_i,
    input  logic [WORD_W-1:0] data_wdata_i,
    output logic              data_rvalid_o,
    output logic [WORD_W-1:0] data_rdata_o,
    input  logic              load_we_i,
    input  logic [31:0]       load_addr_i,
    input  logic [WORD_W-1:0] load_wdata_i,
    input  logic [31:0]       signature_addr_i,
    output logic              test_done_o,
    output logic              err_o
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    if ((INSTR_LATENCY < 1) || (INSTR_LATENCY > MAX_LATENCY) ||
        (DATA_LATENCY < 1) || (DATA_LATENCY > MAX_LATENCY) ||
        (BASE_ADDR[1:0] != 2'b00) || (DEPTH_WORDS < 1) || (DONE_DELAY < 0)) begin : g_bad_params
        $error("miriscv_dp_mem_model: illegal parameter combination");
    end

    function automatic logic addr_oor(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return (addr < BASE_ADDR) || ((off >> 2) >= 32'(DEPTH_WORDS));
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
        logic [31:0] widx;
        widx = (addr - BASE_ADDR) >> 2;
        return widx[IDX_W-1:0];
    endfunction

    logic [WORD_W-1:0] mem_r [DEPTH_WORDS];

    logic              instr_oor_s;
    logic              data_oor_s;
    logic              load_oor_s;
    logic [IDX_W-1:0]  instr_idx_s;
    logic [IDX_W-1:0]  data_idx_s;
    logic [IDX_W-1:0]  load_idx_s;
    logic [WORD_W-1:0] instr_rd_s;
    logic [WORD_W-1:0] data_rd_s;
    logic              data_wr_en_s;
    logic              load_wr_en_s;
    logic              sig_hit_s;
    logic              err_r;
    logic              test_done_r;
    done_state_e       state_r;
    done_state_e       state_next_s;
    logic [31:0]       cnt_r;
    logic [31:0]       cnt_next_s;

    assign instr_oor_s  = addr_oor(instr_addr_i);
    assign data_oor_s   = addr_oor(data_addr_i);
    assign load_oor_s   = addr_oor(load_addr_i);
    assign instr_idx_s  = addr_idx(instr_addr_i);
    assign data_idx_s   = addr_idx(data_addr_i);
    assign load_idx_s   = addr_idx(load_addr_i);
    assign data_wr_en_s = data_req_i & data_we_i & ~data_oor_s;
    assign load_wr_en_s = load_we_i & ~load_oor_s;

    // Array is read in the request cycle, so a same-cycle write is not yet visible.
    always_comb begin
        instr_rd_s = OOR_RDATA;
        data_rd_s  = OOR_RDATA;
        if (!instr_oor_s) begin
            instr_rd_s = mem_r[instr_idx_s];
        end else begin
            instr_rd_s = OOR_RDATA;
        end
        if (data_we_i) begin
            data_rd_s = 32'h0000_0000;
        end else if (!data_oor_s) begin
            data_rd_s = mem_r[data_idx_s];
        end else begin
            data_rd_s = OOR_RDATA;
        end
    end

    // Array writes ignore reset; the load write is issued last so it wins a collision.
    always_ff @(posedge clk) begin
        if (data_wr_en_s) begin
            mem_r[data_idx_s] <= be_merge(mem_r[data_idx_s], data_wdata_i, data_be_i);
        end
        if (load_wr_en_s) begin
            mem_r[load_idx_s] <= load_wdata_i;
        end
    end

    miriscv_mem_rsp_pipe #(
        .LATENCY (INSTR_LATENCY)
    ) u_instr_pipe (
        .clk       (clk),
        .arstn     (arstn),
        .in_valid  (instr_req_i),
        .in_data   (instr_rd_s),
        .out_valid (instr_rvalid_o),
        .out_data  (instr_rdata_o)
    );

    miriscv_mem_rsp_pipe #(
        .LATENCY (DATA_LATENCY)
    ) u_data_pipe (
        .clk       (clk),
        .arstn     (arstn),
        .in_valid  (data_req_i),
        .in_data   (data_rd_s),
        .out_valid (data_rvalid_o),
        .out_data  (data_rdata_o)
    );

    // Sticky out-of-range flag covering all three ports.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r | (instr_req_i & instr_oor_s) | (data_req_i & data_oor_s)
                           | (load_we_i & load_oor_s);
        end
    end

    assign sig_hit_s = data_req_i & data_we_i & (data_addr_i == signature_addr_i)
                     & (data_wdata_i == 32'h0000_0000);

    // Done detector next-state: arm on signature write, count down, then latch.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (sig_hit_s) begin
                    if (DONE_DELAY == 0) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_COUNT;
                        cnt_next_s   = 32'(DONE_DELAY) - 32'd1;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (cnt_r == 32'd0) begin
                    state_next_s = ST_DONE;
                end else begin
                    cnt_next_s = cnt_r - 32'd1;
                end
            end
            ST_DONE: begin
                state_next_s = ST_DONE;
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 32'd0;
            end
        endcase
    end

    // Done detector state, counter and registered flag.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 32'd0;
            test_done_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            test_done_r <= (state_next_s == ST_DONE);
        end
    end

    assign test_done_o = test_done_r;
    assign err_o       = err_r;

endmodule

// File: tb/tb_miriscv_dp_mem_model.sv
// Directed bench: instance A (1024 words, fetch latency 3, data latency 2,
// done delay 10) and instance B (16 words, latency 1, done delay 0).
module tb_miriscv_dp_mem_model;

    logic clk = 1'b0;
    logic arstn = 1'b0;

    logic        a_instr_req, a_instr_rvalid, a_data_req, a_data_we, a_data_rvalid;
    logic [31:0] a_instr_addr, a_instr_rdata, a_data_addr, a_data_wdata, a_data_rdata;
    logic [3:0]  a_data_be;
    logic        a_load_we, a_done, a_err;
    logic [31:0] a_load_addr, a_load_wdata, a_sig_addr;

    logic        b_instr_req, b_instr_rvalid, b_data_req, b_data_we, b_data_rvalid;
    logic [31:0] b_instr_addr, b_instr_rdata, b_data_addr, b_data_wdata, b_data_rdata;
    logic [3:0]  b_data_be;
    logic        b_load_we, b_done, b_err;
    logic [31:0] b_load_addr, b_load_wdata, b_sig_addr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    miriscv_dp_mem_model #(
        .DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .INSTR_LATENCY(3),
        .DATA_LATENCY(2), .DONE_DELAY(10)
    ) u_a (
        .clk(clk), .arstn(arstn),
        .instr_req_i(a_instr_req), .instr_addr_i(a_instr_addr),
        .instr_rvalid_o(a_instr_rvalid), .instr_rdata_o(a_instr_rdata),
        .data_req_i(a_data_req), .data_we_i(a_data_we), .data_be_i(a_data_be),
        .data_addr_i(a_data_addr), .data_wdata_i(a_data_wdata),
        .data_rvalid_o(a_data_rvalid), .data_rdata_o(a_data_rdata),
        .load_we_i(a_load_we), .load_addr_i(a_load_addr), .load_wdata_i(a_load_wdata),
        .signature_addr_i(a_sig_addr), .test_done_o(a_done), .err_o(a_err)
    );

    miriscv_dp_mem_model #(
        .DEPTH_WORDS(16), .BASE_ADDR(32'h0000_0000), .INSTR_LATENCY(1),
        .DATA_LATENCY(1), .DONE_DELAY(0)
    ) u_b (
        .clk(clk), .arstn(arstn),
        .instr_req_i(b_instr_req), .instr_addr_i(b_instr_addr),
        .instr_rvalid_o(b_instr_rvalid), .instr_rdata_o(b_instr_rdata),
        .data_req_i(b_data_req), .data_we_i(b_data_we), .data_be_i(b_data_be),
        .data_addr_i(b_data_addr), .data_wdata_i(b_data_wdata),
        .data_rvalid_o(b_data_rvalid), .data_rdata_o(b_data_rdata),
        .load_we_i(b_load_we), .load_addr_i(b_load_addr), .load_wdata_i(b_load_wdata),
        .signature_addr_i(b_sig_addr), .test_done_o(b_done), .err_o(b_err)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_a(input logic [31:0] addr, input logic [31:0] wdata);
        a_load_we = 1'b1; a_load_addr = addr; a_load_wdata = wdata;
        tick(1);
        a_load_we = 1'b0;
    endtask

    task automatic load_b(input logic [31:0] addr, input logic [31:0] wdata);
        b_load_we = 1'b1; b_load_addr = addr; b_load_wdata = wdata;
        tick(1);
        b_load_we = 1'b0;
    endtask

    task automatic a_data(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata);
        a_data_req = 1'b1; a_data_we = we; a_data_be = be;
        a_data_addr = addr; a_data_wdata = wdata;
    endtask

    task automatic b_data(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata);
        b_data_req = 1'b1; b_data_we = we; b_data_be = be;
        b_data_addr = addr; b_data_wdata = wdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [31:0] exp_burst [5];
        exp_burst[0] = 32'h0000_0013; exp_burst[1] = 32'h0000_00A1;
        exp_burst[2] = 32'h0000_00A2; exp_burst[3] = 32'h0000_00A3;
        exp_burst[4] = 32'h0000_00A4;

        a_instr_req = 1'b0; a_instr_addr = 32'h0; a_data_req = 1'b0; a_data_we = 1'b0;
        a_data_be = 4'h0; a_data_addr = 32'h0; a_data_wdata = 32'h0; a_load_we = 1'b0;
        a_load_addr = 32'h0; a_load_wdata = 32'h0; a_sig_addr = 32'h8000_0000;
        b_instr_req = 1'b0; b_instr_addr = 32'h0; b_data_req = 1'b0; b_data_we = 1'b0;
        b_data_be = 4'h0; b_data_addr = 32'h0; b_data_wdata = 32'h0; b_load_we = 1'b0;
        b_load_addr = 32'h0; b_load_wdata = 32'h0; b_sig_addr = 32'h0000_0004;

        // Preload while reset is asserted.
        tick(2);
        load_a(32'h0000_0000, 32'h0000_0013);
        load_a(32'h0000_0004, 32'h0000_00A1);
        load_a(32'h0000_0008, 32'h0000_00A2);
        load_a(32'h0000_000C, 32'h0000_00A3);
        load_a(32'h0000_0010, 32'h0000_00A4);
        load_a(32'h0000_0100, 32'h1122_3344);
        load_a(32'h0000_0080, 32'h0000_0001);
        load_b(32'h0000_0000, 32'h5A5A_0000);
        load_b(32'h0000_003C, 32'h0000_A5A5);

        check("rst_instr_rvalid", {31'h0, a_instr_rvalid}, 32'h0);
        check("rst_instr_rdata", a_instr_rdata, 32'h0);
        check("rst_data_rvalid", {31'h0, a_data_rvalid}, 32'h0);
        check("rst_data_rdata", a_data_rdata, 32'h0);
        check("rst_done", {31'h0, a_done}, 32'h0);
        check("rst_err", {31'h0, a_err}, 32'h0);
        check("rst_b_err", {31'h0, b_err}, 32'h0);

        arstn = 1'b1;
        tick(1);

        // Single fetch with latency 3.
        a_instr_req = 1'b1; a_instr_addr = 32'h0;
        tick(1); a_instr_req = 1'b0;
        check("fetch_lat_t1", {31'h0, a_instr_rvalid}, 32'h0);
        tick(1);
        check("fetch_lat_t2", {31'h0, a_instr_rvalid}, 32'h0);
        tick(1);
        check("fetch_lat_t3_valid", {31'h0, a_instr_rvalid}, 32'h1);
        check("fetch_lat_t3_data", a_instr_rdata, 32'h0000_0013);
        tick(1);
        check("fetch_lat_t4_valid", {31'h0, a_instr_rvalid}, 32'h0);
        check("fetch_lat_t4_data", a_instr_rdata, 32'h0);

        // Byte-enabled write then unaligned read of the same word.
        a_data(1'b1, 4'b0101, 32'h0000_0100, 32'hAABB_CCDD);
        tick(1); a_data_req = 1'b0;
        check("wr_rsp_t1_valid", {31'h0, a_data_rvalid}, 32'h0);
        tick(1);
        check("wr_rsp_valid", {31'h0, a_data_rvalid}, 32'h1);
        check("wr_rsp_data", a_data_rdata, 32'h0);
        a_data(1'b0, 4'b0000, 32'h0000_0102, 32'h0);
        tick(1); a_data_req = 1'b0;
        tick(1);
        check("be_read_valid", {31'h0, a_data_rvalid}, 32'h1);
        check("be_read_data", a_data_rdata, 32'h11BB_33DD);

        // Five back-to-back fetches.
        for (int i = 0; i < 8; i++) begin
            a_instr_req = (i < 5) ? 1'b1 : 1'b0;
            a_instr_addr = 32'(4 * i);
            tick(1);
            if (i >= 2 && i <= 6) begin
                check("burst_valid", {31'h0, a_instr_rvalid}, 32'h1);
                check("burst_data", a_instr_rdata, exp_burst[i-2]);
            end else begin
                check("burst_idle", {31'h0, a_instr_rvalid}, 32'h0);
            end
        end
        a_instr_req = 1'b0;

        // Fetch racing a data write to the same word, then fetch again.
        a_instr_req = 1'b1; a_instr_addr = 32'h0000_0080;
        a_data(1'b1, 4'b1111, 32'h0000_0080, 32'hFFFF_FFFF);
        tick(1); a_data_req = 1'b0;
        tick(1); a_instr_req = 1'b0;
        tick(1);
        check("hazard_old", a_instr_rdata, 32'h0000_0001);
        tick(1);
        check("hazard_new", a_instr_rdata, 32'hFFFF_FFFF);

        // Load and data write colliding on one word: load wins.
        a_load_we = 1'b1; a_load_addr = 32'h0000_00C0; a_load_wdata = 32'h1234_5678;
        a_data(1'b1, 4'b1111, 32'h0000_00C0, 32'hFFFF_FFFF);
        tick(1); a_load_we = 1'b0;
        a_data(1'b0, 4'b0000, 32'h0000_00C0, 32'h0);
        tick(1); a_data_req = 1'b0;
        tick(1);
        check("collision_load_wins", a_data_rdata, 32'h1234_5678);
        check("a_err_clean", {31'h0, a_err}, 32'h0);

        // Non-zero signature write must not finish the test.
        a_data(1'b1, 4'b1111, 32'h8000_0000, 32'h0000_0001);
        tick(1); a_data_req = 1'b0;
        tick(14);
        check("sig_nonzero_no_done", {31'h0, a_done}, 32'h0);
        check("sig_oor_err", {31'h0, a_err}, 32'h1);

        // Reset in the middle of the countdown.
        a_data(1'b1, 4'b1111, 32'h8000_0000, 32'h0);
        tick(1); a_data_req = 1'b0;
        tick(3);
        arstn = 1'b0; #2; arstn = 1'b1;
        tick(15);
        check("reset_mid_count", {31'h0, a_done}, 32'h0);
        check("reset_clears_err", {31'h0, a_err}, 32'h0);
        a_instr_req = 1'b1; a_instr_addr = 32'h0000_0004;
        tick(1); a_instr_req = 1'b0;
        tick(2);
        check("mem_kept_over_reset", a_instr_rdata, 32'h0000_00A1);

        // Full countdown.
        a_data(1'b1, 4'b1111, 32'h8000_0000, 32'h0);
        tick(1); a_data_req = 1'b0;
        tick(8);
        check("done_early", {31'h0, a_done}, 32'h0);
        tick(2);
        check("done_set", {31'h0, a_done}, 32'h1);
        a_data(1'b1, 4'b1111, 32'h8000_0000, 32'h0);
        tick(1); a_data_req = 1'b0;
        tick(5);
        check("done_sticky", {31'h0, a_done}, 32'h1);

        // Small array: last word, then first out-of-range word.
        b_data(1'b0, 4'b0000, 32'h0000_003C, 32'h0);
        tick(1); b_data_req = 1'b0;
        check("b_last_word", b_data_rdata, 32'h0000_A5A5);
        check("b_err_before", {31'h0, b_err}, 32'h0);
        b_data(1'b0, 4'b0000, 32'h0000_0040, 32'h0);
        tick(1); b_data_req = 1'b0;
        check("b_oor_valid", {31'h0, b_data_rvalid}, 32'h1);
        check("b_oor_rdata", b_data_rdata, 32'h0);
        check("b_oor_err", {31'h0, b_err}, 32'h1);
        tick(3);
        check("b_err_sticky", {31'h0, b_err}, 32'h1);
        b_data(1'b1, 4'b1111, 32'h0000_0040, 32'hFFFF_FFFF);
        tick(1);
        b_data(1'b0, 4'b0000, 32'h0000_0000, 32'h0);
        tick(1);
        check("b_oor_wr_word0", b_data_rdata, 32'h5A5A_0000);
        b_data(1'b0, 4'b0000, 32'h0000_003C, 32'h0);
        tick(1); b_data_req = 1'b0;
        check("b_oor_wr_word15", b_data_rdata, 32'h0000_A5A5);

        // Zero done delay: flag rises right after the detection cycle.
        b_data(1'b1, 4'b1111, 32'h0000_0004, 32'h0);
        check("b_done_before", {31'h0, b_done}, 32'h0);
        tick(1); b_data_req = 1'b0;
        check("b_done_immediate", {31'h0, b_done}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
